// File: rtl/dram_write_arbiter_if.sv
// Bundles the two requester handshakes and the RAM write port of the
// distributed-RAM write arbiter. The slave modport is the arbiter side;
// the master modport is the requester/RAM side.
interface dram_write_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;

  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready,
    output ram_we, ram_waddr, ram_wdata
  );

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready,
    input  ram_we, ram_waddr, ram_wdata
  );
endinterface

// File: rtl/dram_write_arbiter.sv
// Owns the single write port of a 32-deep quad-port distributed RAM.
// Out of reset (and on clear_req) it sweeps every address with CLEAR_VAL;
// otherwise it round-robins two valid/ready requesters onto the port.
// Ready is combinational from valid and state; the RAM write is registered,
// so an accepted write reaches the RAM pins one cycle later.
module dram_write_arbiter #(
  parameter int                ADDR_W    = 5,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dram_write_arbiter_if.slave   bus,
  input  logic                  clear_req,
  output logic                  clearing,
  output logic                  last_grant
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              grant_q, grant_d;   // 0 = A, 1 = B
  logic              a_ready_c, b_ready_c;
  logic              pick_a, pick_b;

  // Round-robin pick: a lone requester wins, a tie goes to the one not
  // granted last time. Depends only on valids and last grant, never on ready.
  always_comb begin
    pick_a = bus.a_valid && (!bus.b_valid || grant_q);
    pick_b = bus.b_valid && (!bus.a_valid || !grant_q);
  end

  // Next-state, handshake and write-port decode for the CLEAR/RUN machine.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    grant_d   = grant_q;
    a_ready_c = 1'b0;
    b_ready_c = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = CLEAR_VAL;
        cnt_d   = cnt_q + 1'b1;   // wraps to 0 after the last address
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          // A new sweep pre-empts arbitration for this cycle.
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (pick_a) begin
          a_ready_c = 1'b1;
          we_d      = 1'b1;
          waddr_d   = bus.a_addr;
          wdata_d   = bus.a_data;
          grant_d   = 1'b0;
        end else if (pick_b) begin
          b_ready_c = 1'b1;
          we_d      = 1'b1;
          waddr_d   = bus.b_addr;
          wdata_d   = bus.b_data;
          grant_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // State, sweep counter, registered RAM write port and grant history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
    end
  end

  assign bus.a_ready   = a_ready_c;
  assign bus.b_ready   = b_ready_c;
  assign bus.ram_we    = we_q;
  assign bus.ram_waddr = waddr_q;
  assign bus.ram_wdata = wdata_q;
  assign clearing      = (state_q == ST_CLEAR);
  assign last_grant    = grant_q;

endmodule

// File: tb/tb_dram_write_arbiter.sv
// Directed bench for the distributed-RAM write arbiter. Stimulus pushes the
// expected RAM writes into a queue; a monitor pops and compares whenever
// ram_we is seen high. Handshake and status outputs are checked inline.
module tb_dram_write_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear_req = 1'b0;
  logic clearing;
  logic last_grant;

  dram_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dram_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_VAL(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clear_req (clear_req),
    .clearing  (clearing),
    .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [AW+DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_w(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic push_sweep(input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = AW'(i);
      push_w(a, 8'h00);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Watches the 32 CLEAR cycles: clearing high, no ready even if requested.
  task automatic watch_sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk({tag, "_clearing"}, clearing, 1'b1);
      chk({tag, "_a_ready"}, bus.a_ready, 1'b0);
      chk({tag, "_b_ready"}, bus.b_ready, 1'b0);
      step();
    end
  endtask

  // Monitor: every RAM write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && bus.ram_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected no write (t=%0t)",
                 bus.ram_waddr, bus.ram_wdata, $time);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        $display("WR addr %0d data %02h (t=%0t)", bus.ram_waddr, bus.ram_wdata, $time);
        chk("wr_addr", bus.ram_waddr, e[AW+DW-1:DW]);
        chk("wr_data", bus.ram_wdata, e[DW-1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_addr_t[3];
    int a_dat_t[3];
    int b_addr_t[3];
    int b_dat_t[3];
    int ia;
    int ib;

    a_addr_t = '{1, 2, 3};     a_dat_t = '{'h11, 'h12, 'h13};
    b_addr_t = '{17, 18, 19};  b_dat_t = '{'h21, 'h22, 'h23};

    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;

    // Reset values (asynchronous, before any clock edge).
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ram_we", bus.ram_we, 1'b0);
    chk("rst_waddr", bus.ram_waddr, 5'd0);
    chk("rst_wdata", bus.ram_wdata, 8'h00);
    chk("rst_last_grant", last_grant, 1'b1);
    chk("rst_clearing", clearing, 1'b1);
    chk("rst_a_ready", bus.a_ready, 1'b0);
    chk("rst_b_ready", bus.b_ready, 1'b0);

    // Initial sweep: 32 clear writes, addresses 0..31.
    push_sweep(32);
    step();
    step();
    rst_n = 1'b1;
    watch_sweep("sweep0");

    // Single A write.
    bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 8'hA5;
    @(negedge clk);
    chk("a1_clearing", clearing, 1'b0);
    chk("a1_a_ready", bus.a_ready, 1'b1);
    chk("a1_b_ready", bus.b_ready, 1'b0);
    push_w(5'd7, 8'hA5);
    step();
    bus.a_valid = 1'b0;
    @(negedge clk);
    chk("a1_last_grant", last_grant, 1'b0);
    chk("a1_idle_a_ready", bus.a_ready, 1'b0);
    step();

    // Both valid for 6 grants; A was granted last, so B goes first.
    ia = 0; ib = 0;
    bus.a_valid = 1'b1; bus.a_addr = AW'(a_addr_t[0]); bus.a_data = DW'(a_dat_t[0]);
    bus.b_valid = 1'b1; bus.b_addr = AW'(b_addr_t[0]); bus.b_data = DW'(b_dat_t[0]);
    for (int k = 0; k < 6; k++) begin
      logic want_b;
      want_b = (k % 2 == 0);
      @(negedge clk);
      chk("rr_a_ready", bus.a_ready, !want_b);
      chk("rr_b_ready", bus.b_ready, want_b);
      if (want_b) push_w(AW'(b_addr_t[ib]), DW'(b_dat_t[ib]));
      else        push_w(AW'(a_addr_t[ia]), DW'(a_dat_t[ia]));
      step();
      if (want_b) begin
        ib++;
        if (ib < 3) begin bus.b_addr = AW'(b_addr_t[ib]); bus.b_data = DW'(b_dat_t[ib]); end
      end else begin
        ia++;
        if (ia < 3) begin bus.a_addr = AW'(a_addr_t[ia]); bus.a_data = DW'(a_dat_t[ia]); end
      end
    end

    // clear_req while both valid: no grant that cycle, then a full sweep.
    bus.a_addr = 5'd4;  bus.a_data = 8'h14;
    bus.b_addr = 5'd20; bus.b_data = 8'h24;
    clear_req = 1'b1;
    @(negedge clk);
    chk("clr_a_ready", bus.a_ready, 1'b0);
    chk("clr_b_ready", bus.b_ready, 1'b0);
    chk("clr_last_grant", last_grant, 1'b0);
    push_sweep(32);
    step();
    clear_req = 1'b0;
    watch_sweep("sweep1");
    @(negedge clk);
    chk("post1_clearing", clearing, 1'b0);
    chk("post1_last_grant", last_grant, 1'b0);
    chk("post1_b_ready", bus.b_ready, 1'b1);
    chk("post1_a_ready", bus.a_ready, 1'b0);
    push_w(5'd20, 8'h24);
    step();
    bus.b_valid = 1'b0;
    @(negedge clk);
    chk("post1b_a_ready", bus.a_ready, 1'b1);
    push_w(5'd4, 8'h14);
    step();
    bus.a_valid = 1'b0;
    @(negedge clk);
    chk("post1c_last_grant", last_grant, 1'b0);
    chk("post1c_a_ready", bus.a_ready, 1'b0);
    step();

    // B only, three separate writes.
    for (int k = 0; k < 3; k++) begin
      bus.b_valid = 1'b1; bus.b_addr = AW'(9 + k); bus.b_data = DW'(8'hC0 + k);
      @(negedge clk);
      chk("bonly_b_ready", bus.b_ready, 1'b1);
      chk("bonly_a_ready", bus.a_ready, 1'b0);
      push_w(AW'(9 + k), DW'(8'hC0 + k));
      step();
      bus.b_valid = 1'b0;
      @(negedge clk);
      chk("bonly_idle_b_ready", bus.b_ready, 1'b0);
      chk("bonly_last_grant", last_grant, 1'b1);
      step();
    end

    // Start a sweep, then reset asynchronously with the counter at 12.
    clear_req = 1'b1;
    @(negedge clk);
    chk("clr2_b_ready", bus.b_ready, 1'b0);
    push_sweep(12);
    step();
    clear_req = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ram_we", bus.ram_we, 1'b0);
    chk("arst_waddr", bus.ram_waddr, 5'd0);
    chk("arst_wdata", bus.ram_wdata, 8'h00);
    chk("arst_clearing", clearing, 1'b1);
    chk("arst_last_grant", last_grant, 1'b1);
    chk("arst_pending", exp_q.size(), 0);
    push_sweep(32);
    step();
    step();
    rst_n = 1'b1;
    watch_sweep("sweep2");

    // After reset last_grant is B, so A wins the tie.
    bus.a_valid = 1'b1; bus.a_addr = 5'd30; bus.a_data = 8'h5A;
    bus.b_valid = 1'b1; bus.b_addr = 5'd31; bus.b_data = 8'hE7;
    @(negedge clk);
    chk("post2_clearing", clearing, 1'b0);
    chk("post2_a_ready", bus.a_ready, 1'b1);
    chk("post2_b_ready", bus.b_ready, 1'b0);
    push_w(5'd30, 8'h5A);
    step();
    bus.a_valid = 1'b0;
    @(negedge clk);
    chk("post2b_b_ready", bus.b_ready, 1'b1);
    push_w(5'd31, 8'hE7);
    step();
    bus.b_valid = 1'b0;
    repeat (3) step();
    chk("final_pending", exp_q.size(), 0);
    chk("final_last_grant", last_grant, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
